// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, a rotating search pointer,
// and an optional hold limit that forces the current owner to release.
module rr_arbiter #(
  parameter int REQCNT   = 3,
  parameter int REQWIDTH = $clog2(REQCNT),
  parameter int MAX_HOLD = 4,
  parameter int HCNTW    = ($clog2(MAX_HOLD+1) > 0 ? $clog2(MAX_HOLD+1) : 1)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [REQCNT-1:0]   req_i,
  output logic [REQCNT-1:0]   gnt_o,
  output logic [REQWIDTH-1:0] gnt_num_o,
  output logic                gnt_valid_o,
  output logic                preempt_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [HCNTW-1:0]    HOLD_LAST = HCNTW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [REQWIDTH-1:0] LAST_IDX  = REQWIDTH'(REQCNT - 1);

  state_t              state_q, state_d;
  logic [REQWIDTH-1:0] ptr_q, ptr_d;
  logic [REQWIDTH-1:0] num_q, num_d;
  logic [HCNTW-1:0]    hold_q, hold_d;
  logic [REQCNT-1:0]   gnt_q, gnt_d;
  logic                pre_q, pre_d;

  logic                win_vld;
  logic [REQWIDTH-1:0] win_num;
  logic [REQWIDTH-1:0] nxt_ptr;

  // Circular search from ptr; the wrap is done in int so non-power-of-two counts work.
  always_comb begin
    int sum;
    win_vld = 1'b0;
    win_num = '0;
    sum     = 0;
    for (int i = 0; i < REQCNT; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= REQCNT) sum = sum - REQCNT;
      if (!win_vld && req_i[REQWIDTH'(sum)]) begin
        win_vld = 1'b1;
        win_num = REQWIDTH'(sum);
      end
    end
  end

  assign nxt_ptr = (num_q == LAST_IDX) ? '0 : num_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    num_d   = num_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    pre_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d        = BUSY;
          num_d          = win_num;
          gnt_d          = '0;
          gnt_d[win_num] = 1'b1;
          hold_d         = '0;
        end
      end
      BUSY: begin
        // Normal release takes priority over the hold limit.
        if (!req_i[num_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          num_d   = '0;
          ptr_d   = nxt_ptr;
        end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
          state_d = IDLE;
          gnt_d   = '0;
          num_d   = '0;
          ptr_d   = nxt_ptr;
          pre_d   = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      num_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_num_o   = num_q;
  assign gnt_valid_o = (state_q == BUSY);
  assign preempt_o   = pre_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations,
// a monitor pops one after every rising edge and compares.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_na = 1'b0, rst_nb = 1'b0;
  logic [2:0] req_a = '0;
  logic [4:0] req_b = '0;

  logic [2:0] gnt_a;  logic [1:0] num_a;  logic val_a, pre_a;
  logic [4:0] gnt_b;  logic [2:0] num_b;  logic val_b, pre_b;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit sel;   // 0: 3-requester instance, 1: 5-requester no-limit instance
    bit v;
    int n;
    bit p;
    string tag;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  rr_arbiter #(.REQCNT(3), .MAX_HOLD(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_na), .req_i(req_a),
    .gnt_o(gnt_a), .gnt_num_o(num_a), .gnt_valid_o(val_a), .preempt_o(pre_a));

  rr_arbiter #(.REQCNT(5), .MAX_HOLD(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_nb), .req_i(req_b),
    .gnt_o(gnt_b), .gnt_num_o(num_b), .gnt_valid_o(val_b), .preempt_o(pre_b));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one request vector and record what must be visible after the next edge.
  task automatic step(input bit sel, input logic [4:0] r, input bit v, input int n,
                      input bit p, input string tag);
    exp_t e;
    @(negedge clk);
    if (sel) req_b = r; else req_a = r[2:0];
    e.sel = sel; e.v = v; e.n = n; e.p = p; e.tag = tag;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk({e.tag, ".gnt"}, int'(gnt_a), e.v ? (1 << e.n) : 0);
          chk({e.tag, ".valid"}, int'(val_a), int'(e.v));
          chk({e.tag, ".preempt"}, int'(pre_a), int'(e.p));
          if (e.v) chk({e.tag, ".num"}, int'(num_a), e.n);
        end else begin
          chk({e.tag, ".gnt"}, int'(gnt_b), e.v ? (1 << e.n) : 0);
          chk({e.tag, ".valid"}, int'(val_b), int'(e.v));
          chk({e.tag, ".preempt"}, int'(pre_b), int'(e.p));
          if (e.v) chk({e.tag, ".num"}, int'(num_b), e.n);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int owners[4];
    owners = '{0, 1, 2, 0};

    repeat (3) @(negedge clk);
    rst_na = 1'b1;
    rst_nb = 1'b1;
    #1;
    chk("reset.gnt_a", int'(gnt_a), 0);
    chk("reset.val_a", int'(val_a), 0);
    chk("reset.num_a", int'(num_a), 0);
    chk("reset.pre_a", int'(pre_a), 0);
    chk("reset.gnt_b", int'(gnt_b), 0);
    chk("reset.val_b", int'(val_b), 0);

    // All requesting: 4-cycle grants rotate 0,1,2,0, each ended by a preempt cycle.
    foreach (owners[k]) begin
      repeat (4) step(0, 5'b00111, 1, owners[k], 0, "rot");
      step(0, 5'b00111, 0, 0, 1, "rot_pre");
    end
    step(0, 5'b00000, 0, 0, 0, "rot_quiet");                 // ptr now 1

    step(0, 5'b00010, 1, 1, 0, "short");
    step(0, 5'b00010, 1, 1, 0, "short");
    step(0, 5'b00000, 0, 0, 0, "short_rel");                 // ptr now 2

    step(0, 5'b00100, 1, 2, 0, "wrap");
    step(0, 5'b00001, 0, 0, 0, "wrap_rel");                  // ptr wraps to 0
    step(0, 5'b00001, 1, 0, 0, "wrap_gnt");
    step(0, 5'b00000, 0, 0, 0, "wrap_quiet");                // ptr now 1

    step(0, 5'b00101, 1, 2, 0, "skip");                      // 1 idle, 2 before 0
    step(0, 5'b00000, 0, 0, 0, "skip_rel");                  // ptr now 0

    repeat (4) step(0, 5'b00001, 1, 0, 0, "edge");
    step(0, 5'b00000, 0, 0, 0, "edge_rel");                  // drop at hold==3: no preempt
    step(0, 5'b00111, 1, 1, 0, "edge_ptr");                  // ptr advanced to 1

    // Asynchronous reset mid-grant.
    @(posedge clk);
    #3;
    rst_na = 1'b0;
    #1;
    chk("async.gnt", int'(gnt_a), 0);
    chk("async.val", int'(val_a), 0);
    chk("async.pre", int'(pre_a), 0);
    @(negedge clk);
    req_a = '0;
    @(negedge clk);
    rst_na = 1'b1;
    step(0, 5'b00111, 1, 0, 0, "post_rst");                  // ptr back to 0
    step(0, 5'b00000, 0, 0, 0, "post_rst_rel");

    // No hold limit, five requesters.
    repeat (10) step(1, 5'b10001, 1, 0, 0, "nolim");
    step(1, 5'b10000, 0, 0, 0, "nolim_rel");                 // ptr now 1
    step(1, 5'b10000, 1, 4, 0, "nolim_g4");
    repeat (2) step(1, 5'b10000, 1, 4, 0, "nolim_g4");
    step(1, 5'b00011, 0, 0, 0, "nolim_rel4");                // ptr wraps to 0
    step(1, 5'b00011, 1, 0, 0, "nolim_wrap");
    step(1, 5'b00000, 0, 0, 0, "nolim_end");

    repeat (4) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
